pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Soft-start / ramp controller that owns the duty-cycle register of the PWM generator. Accepts absolute duty targets over a valid/ready handshake, or relative ±STEP nudges from the front-panel inc/dec strobes, then walks the applied duty toward the target at a fixed step rate. New duty values are committed only at PWM period boundaries so the generator never sees a mid-period change. Sits between the control/button logic and the PWM comparator, driving its `duty_cycle` input.

## Interface
- `WIDTH`, 4: duty and counter width in bits.
- `STEP`, 2: duty increment per ramp step and per inc/dec strobe.
- `PRESCALE`, 4: clock cycles between ramp steps (≥1).
- `MAX_DUTY`, 14: upper duty limit; all targets saturate here.
- `RESET_DUTY`, 8: duty after reset.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `period_end`  in  1  one-cycle pulse from the PWM counter at wrap (counter == all-ones).
- `target_valid`  in  1  absolute target request.
- `target_duty`  in  WIDTH  requested duty; clamped to MAX_DUTY on accept.
- `target_ready`  out  1  high only in IDLE; handshake completes on valid && ready.
- `duty_inc`  in  1  one-cycle strobe: target += STEP (saturating).
- `duty_dec`  in  1  one-cycle strobe: target -= STEP (floor 0).
- `duty_out`  out  WIDTH  committed duty to the PWM comparator (registered).
- `busy`  out  1  high in RAMP or SETTLE.
- `at_target`  out  1  high in IDLE (duty_out == target).

## Operation
- Internal regs: `target`, `cur` (ramp value), `duty_out`, prescaler count, state.
- States: IDLE, RAMP, SETTLE.
- IDLE: requests accepted; priority target_valid > duty_inc > duty_dec. If the resulting target equals `cur`, stay in IDLE (no busy pulse); otherwise go to RAMP and clear the prescaler.
- inc: target = min(cur + STEP, MAX_DUTY). dec: target = cur ≥ STEP ? cur − STEP : 0. Compute in WIDTH+1 bits; no wrap-around.
- RAMP: prescaler counts 0..PRESCALE−1. At terminal count, cur moves toward target by min(STEP, |target − cur|). When cur == target, go to SETTLE.
- SETTLE: wait for period_end, then go to IDLE.
- In every state, period_end loads duty_out ← cur. No other path writes duty_out.
- Requests in RAMP/SETTLE are not accepted: target_ready = 0; strobes are dropped; target_valid must be held by the source.
- Simultaneous step and period_end: duty_out takes the pre-step cur. The new cur commits at the next period_end.

## Timing
- Reset values: duty_out = cur = target = RESET_DUTY; state IDLE; prescaler 0; busy 0; at_target 1; target_ready 1.
- Request accepted at edge N → busy = 1 after edge N.
- First step at edge N+PRESCALE; subsequent steps every PRESCALE cycles.
- Return to IDLE on the first period_end edge after cur reaches target. busy falls in the same cycle duty_out takes the final value.
- rst mid-operation: all registers take reset values on that edge; pending target is discarded.

## Structure
- Shared `pwm_pkg`: WIDTH, MAX_DUTY, RESET_DUTY defaults; state enum {IDLE, RAMP, SETTLE}. The PWM generator uses the same package constants.
- One sub-module: `pwm_step_prescaler`, which emits a step tick every PRESCALE cycles and has a synchronous clear.
- Remaining FSM, clamp and step arithmetic stay in the top module.

## Test plan
Defaults, with period_end pulsing every 16 cycles.
- Reset: rst high for 2 cycles → duty_out = 8, busy = 0, at_target = 1, target_ready = 1.
- Ramp up: target 14 accepted at edge N → cur = 10, 12, 14 at N+4, N+8, N+12; duty_out follows only on period_end edges; IDLE after the first period_end with cur = 14.
- Ramp down with partial step: target 3 from 8 → cur = 6, 4, 3 (final step of 1); duty_out ends at 3; target 15 → clamped to 14.
- Saturation: at duty 14, duty_inc → no busy, duty_out stays 14. At duty 0, duty_dec → stays 0. At duty 13, duty_inc → target 14, one step.
- Priority and stall: target_valid (target 4) and duty_inc in the same IDLE cycle → target = 4. target_valid held during RAMP → not accepted until IDLE, then accepted in the first IDLE cycle.
- Reset mid-ramp: rst at N+6 of a ramp 8→14 → next cycle duty_out = 8, IDLE; earlier request not resumed.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM block family.
// The PWM generator and the duty sequencer both import these defaults.
package pwm_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_STEP       = 2;
  localparam int DEF_PRESCALE   = 4;
  localparam int DEF_MAX_DUTY   = 14;
  localparam int DEF_RESET_DUTY = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pwm_step_prescaler.sv
// Ramp-rate divider: emits a one-cycle tick after every PRESCALE enabled cycles.
// A synchronous clear restarts the count so the first tick lands PRESCALE cycles later.
module pwm_step_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start duty ramp controller: accepts absolute targets or +/-STEP nudges,
// walks the ramp value toward the target, and commits it to duty_out only on period_end.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STEP       = DEF_STEP,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int MAX_DUTY   = DEF_MAX_DUTY,
  parameter int RESET_DUTY = DEF_RESET_DUTY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             period_end,
  input  logic             target_valid,
  input  logic [WIDTH-1:0] target_duty,
  output logic             target_ready,
  input  logic             duty_inc,
  input  logic             duty_dec,
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             at_target
);

  localparam logic [WIDTH:0]   STEP_X  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX_DUTY);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_DUTY);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_DUTY);

  seq_state_e       state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] cur;

  logic             ramp_active;
  logic             step_tick;

  logic             req_any;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH:0]   cur_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   ext_x;

  logic             step_up;
  logic [WIDTH-1:0] gap;
  logic [WIDTH-1:0] stride;
  logic [WIDTH-1:0] cur_stepped;

  assign ramp_active = (state == RAMP);

  pwm_step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (!ramp_active),
    .enable (ramp_active),
    .tick   (step_tick)
  );

  // Request decode; priority target_valid > duty_inc > duty_dec. The extra
  // top bit keeps the saturating add and the floor compare free of wrap-around.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cur_x      = {1'b0, cur};
    ext_x      = {1'b0, target_duty};
    sum_x      = cur_x + STEP_X;
    req_any    = target_valid || duty_inc || duty_dec;
    req_target = cur;
    if (target_valid) begin
      req_target = (ext_x > MAX_X) ? MAX_W : target_duty;
    end else if (duty_inc) begin
      req_target = (sum_x > MAX_X) ? MAX_W : sum_x[WIDTH-1:0];
    end else if (duty_dec) begin
      req_target = (cur_x >= STEP_X) ? cur - STEP_W : '0;
    end
  end

  // One ramp step: move by STEP, or by the remaining gap if that is smaller.
  always_comb begin
    step_up     = (target > cur);
    gap         = step_up ? (target - cur) : (cur - target);
    stride      = (gap > STEP_W) ? STEP_W : gap;
    cur_stepped = step_up ? (cur + stride) : (cur - stride);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      target       <= RESET_W;
      cur          <= RESET_W;
      duty_out     <= RESET_W;
      busy         <= 1'b0;
      at_target    <= 1'b1;
      target_ready <= 1'b1;
    end else begin
      // The comparator only ever sees period-aligned updates; a step landing
      // on the same edge is committed at the following period_end.
      if (period_end) begin
        duty_out <= cur;
      end

      case (state)
        IDLE: begin
          if (req_any) begin
            target <= req_target;
            if (req_target != cur) begin
              state        <= RAMP;
              busy         <= 1'b1;
              at_target    <= 1'b0;
              target_ready <= 1'b0;
            end
          end
        end

        RAMP: begin
          if (step_tick) begin
            cur <= cur_stepped;
            if (cur_stepped == target) begin
              state <= SETTLE;
            end
          end
        end

        SETTLE: begin
          // duty_out picks up the final cur on this same edge.
          if (period_end) begin
            state        <= IDLE;
            busy         <= 1'b0;
            at_target    <= 1'b1;
            target_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          at_target    <= 1'b1;
          target_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: reset/handshake vector table, hand-written ramp
// corner sequences, then randomized traffic against a behavioural duty model.
module tb_pwm_duty_sequencer;

  localparam int MAXD   = 14;
  localparam int STEPV  = 2;
  localparam int PRESC  = 4;
  localparam int RSTD   = 8;

  logic       clk;
  logic       rst;
  logic       period_end;
  logic       target_valid;
  logic [3:0] target_duty;
  logic       target_ready;
  logic       duty_inc;
  logic       duty_dec;
  logic [3:0] duty_out;
  logic       busy;
  logic       at_target;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: duty values as plain integers, steps scheduled by absolute cycle number.
  int m_cur, m_target, m_duty, m_next_step;
  bit m_busy, m_reached;

  pwm_duty_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .period_end   (period_end),
    .target_valid (target_valid),
    .target_duty  (target_duty),
    .target_ready (target_ready),
    .duty_inc     (duty_inc),
    .duty_dec     (duty_dec),
    .duty_out     (duty_out),
    .busy         (busy),
    .at_target    (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void model_edge(input logic r, input logic pe, input logic tv,
                                     input logic [3:0] td, input logic inc, input logic dec);
    int want, gap, mv;
    if (r) begin
      m_cur = RSTD; m_target = RSTD; m_duty = RSTD;
      m_busy = 0; m_reached = 0; m_next_step = 0;
      return;
    end
    if (pe) m_duty = m_cur;
    if (!m_busy) begin
      if (tv || inc || dec) begin
        if (tv)       want = (int'(td) > MAXD) ? MAXD : int'(td);
        else if (inc) want = (m_cur + STEPV > MAXD) ? MAXD : m_cur + STEPV;
        else          want = (m_cur >= STEPV) ? m_cur - STEPV : 0;
        m_target = want;
        if (want != m_cur) begin
          m_busy = 1; m_reached = 0; m_next_step = cyc + PRESC;
        end
      end
    end else if (!m_reached) begin
      if (cyc == m_next_step) begin
        gap = m_target - m_cur;
        mv  = (gap < 0) ? -gap : gap;
        if (mv > STEPV) mv = STEPV;
        m_cur = (gap > 0) ? m_cur + mv : m_cur - mv;
        m_next_step = m_next_step + PRESC;
        if (m_cur == m_target) m_reached = 1;
      end
    end else if (pe) begin
      m_busy = 0;
    end
  endfunction

  task automatic step_cycle(input logic r, input logic pe, input logic tv,
                            input logic [3:0] td, input logic inc, input logic dec);
    rst = r; period_end = pe; target_valid = tv; target_duty = td;
    duty_inc = inc; duty_dec = dec;
    @(posedge clk);
    model_edge(r, pe, tv, td, inc, dec);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(0, 0, 0, 4'd0, 0, 0);
  endtask

  // Run with a free-running 16-cycle period_end until busy drops (bounded).
  task automatic settle(input string name, input logic [3:0] exp_duty);
    int n;
    n = 0;
    do begin
      step_cycle(0, (cyc % 16) == 15, 0, 4'd0, 0, 0);
      n++;
    end while (busy && n < 300);
    check({name, " busy"}, busy, 0);
    check({name, " duty"}, duty_out, exp_duty);
  endtask

  typedef struct {
    logic       r;
    logic       tv;
    logic [3:0] td;
    logic       inc;
    logic       dec;
    logic [3:0] e_duty;
    logic       e_busy;
    logic       e_ready;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1; period_end = 0; target_valid = 0; target_duty = 0;
    duty_inc = 0; duty_dec = 0;

    // Single-cycle vectors with period_end held low.
    vecs[0] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'd8,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd8, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      step_cycle(vecs[i].r, 0, vecs[i].tv, vecs[i].td, vecs[i].inc, vecs[i].dec);
      check($sformatf("vec%0d duty", i), duty_out, vecs[i].e_duty);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d ready", i), target_ready, vecs[i].e_ready);
      check($sformatf("vec%0d at_target", i), at_target, !vecs[i].e_busy);
    end

    // Ramp up 8 -> 14: steps at N+4, N+8, N+12; period_end at N+6, N+12, N+16.
    step_cycle(0, 0, 1, 4'd14, 0, 0);
    check("up accept busy", busy, 1);
    idle(5);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("up N+6 duty", duty_out, 10);
    idle(5);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("up N+12 pre-step duty", duty_out, 12);
    check("up N+12 busy", busy, 1);
    idle(3);
    check("up settle busy", busy, 1);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("up final duty", duty_out, 14);
    check("up final busy", busy, 0);
    check("up final at_target", at_target, 1);

    // Ramp down 8 -> 3 with a final partial step of 1.
    step_cycle(1, 0, 0, 4'd0, 0, 0);
    step_cycle(0, 0, 1, 4'd3, 0, 0);
    idle(8);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("down N+9 duty", duty_out, 4);
    check("down N+9 busy", busy, 1);
    idle(3);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("down final duty", duty_out, 3);
    check("down final busy", busy, 0);

    // Out-of-range target clamps to the upper limit.
    step_cycle(0, 0, 1, 4'd15, 0, 0);
    check("clamp busy", busy, 1);
    settle("clamp", 4'd14);

    // Saturation at both ends, then a single step from 13 to 14.
    step_cycle(0, 0, 0, 4'd0, 1, 0);
    check("sat hi busy", busy, 0);
    idle(1);
    check("sat hi duty", duty_out, 14);
    step_cycle(0, 0, 1, 4'd0, 0, 0);
    settle("to zero", 4'd0);
    step_cycle(0, 0, 0, 4'd0, 0, 1);
    check("sat lo busy", busy, 0);
    idle(1);
    check("sat lo duty", duty_out, 0);
    step_cycle(0, 0, 1, 4'd13, 0, 0);
    settle("to 13", 4'd13);
    step_cycle(0, 0, 0, 4'd0, 1, 0);
    check("13 inc busy", busy, 1);
    idle(4);
    check("13 inc settle busy", busy, 1);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("13 inc duty", duty_out, 14);
    check("13 inc done", busy, 0);

    // target_valid beats duty_inc in the same cycle.
    step_cycle(0, 0, 1, 4'd4, 1, 0);
    settle("priority", 4'd4);

    // Held target_valid stalls during the ramp and is taken in the first IDLE cycle.
    begin
      int n;
      step_cycle(0, 0, 1, 4'd10, 0, 0);
      step_cycle(0, 0, 1, 4'd6, 0, 0);
      check("stall ready low", target_ready, 0);
      n = 0;
      while (busy && n < 300) begin
        step_cycle(0, (cyc % 16) == 15, 1, 4'd6, 0, 0);
        n++;
      end
      check("stall reached idle", busy, 0);
      check("stall ready high", target_ready, 1);
      check("stall first duty", duty_out, 10);
      step_cycle(0, 0, 1, 4'd6, 0, 0);
      check("stall accepted", busy, 1);
      settle("stall", 4'd6);
    end

    // Reset mid-ramp discards the pending target.
    step_cycle(1, 0, 0, 4'd0, 0, 0);
    step_cycle(0, 0, 1, 4'd14, 0, 0);
    idle(4);
    step_cycle(0, 1, 0, 4'd0, 0, 0);
    check("midrst pre duty", duty_out, 10);
    step_cycle(1, 0, 0, 4'd0, 0, 0);
    check("midrst duty", duty_out, 8);
    check("midrst busy", busy, 0);
    check("midrst ready", target_ready, 1);
    for (int i = 0; i < 40; i++) step_cycle(0, (cyc % 16) == 15, 0, 4'd0, 0, 0);
    check("midrst no resume busy", busy, 0);
    check("midrst no resume duty", duty_out, 8);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, tv, inc, dec;
      logic [3:0] td;
      r   = ($urandom_range(0, 299) == 0);
      tv  = ($urandom_range(0, 9) == 0);
      inc = ($urandom_range(0, 9) == 0);
      dec = ($urandom_range(0, 9) == 0);
      td  = 4'($urandom_range(0, 15));
      step_cycle(r, (cyc % 16) == 15, tv, td, inc, dec);
      check("rand outputs", {duty_out, busy, at_target, target_ready},
            {4'(m_duty), m_busy, !m_busy, !m_busy});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
